// File: rtl/arb_pkg.sv
// arb_pkg: definitions shared by the burst multiplexer and its helpers.
//   state_t        - FSM encoding (ST_IDLE=0, ST_WAIT=1, ST_BURST=2)
//   DEF_N          - default channel count (must match the arbiter)
//   DEF_DW         - default data width per channel
//   DEF_MAX_BURST  - default maximum beats per grant
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam int DEF_N         = 16;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/onehot_to_idx.sv
// onehot_to_idx: converts a (nominally) one-hot vector to a binary index.
// When several bits are set, the lowest set bit wins. An all-zero input
// gives idx=0 with any=0.
// Ports:
//   onehot  in  N   one-hot vector
//   idx     out SW  binary index of the lowest set bit
//   any     out 1   at least one bit is set
module onehot_to_idx
  import arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  onehot,
  output logic [SW-1:0] idx,
  output logic          any
);

  // Scan from the top down so that the lowest set bit is written last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (onehot[i]) idx = SW'(i);
    end
  end

  assign any = |onehot;

endmodule

// File: rtl/arb_burst_mux.sv
// arb_burst_mux: collects N producer streams, requests one arbitration per
// burst from an external round-robin arbiter (registered one-hot grant,
// 1-cycle latency), then locks the shared output to the granted channel
// until out_last is transferred.
// Optional build macro: ARB_BURST_TIMEOUT_EN adds parameter TIMEOUT and the
// sticky output tmo_err; a burst whose owner stays invalid for TIMEOUT
// consecutive cycles is abandoned without out_last.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/data/last   per-channel stream; channel i data at [i*DW +: DW]
//   in_ready             per-channel accept, at most one bit set
//   arb_req              request vector to the arbiter (one-cycle pulse)
//   arb_grant            registered one-hot grant from the arbiter
//   out_valid/data/last  shared output stream, out_ready from the sink
//   out_src              binary index of the current owner
//   busy                 high whenever the FSM is not idle
//   state_dbg            current FSM state (state_t encoding)
//   tmo_err              (ARB_BURST_TIMEOUT_EN only) sticky stall timeout
//
// Handshake: a beat moves when out_valid & out_ready. out_valid is a pure
// function of the owner's in_valid and never looks at out_ready; in_ready of
// the owner is out_ready itself, so producer and sink see the same transfer.
module arb_burst_mux
  import arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
`ifdef ARB_BURST_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          in_valid,
  input  logic [N*DW-1:0]       in_data,
  input  logic [N-1:0]          in_last,
  output logic [N-1:0]          in_ready,
  output logic [N-1:0]          arb_req,
  input  logic [N-1:0]          arb_grant,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [$clog2(N)-1:0]  out_src,
  output logic                  busy,
  output logic [1:0]            state_dbg
`ifdef ARB_BURST_TIMEOUT_EN
  , output logic                tmo_err
`endif
);

  localparam int SW  = $clog2(N);
  // Sized so that MAX_BURST itself is representable; the forced last beat
  // ends the burst before the counter could wrap.
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_BURST - 1);

  state_t          state;
  logic [SW-1:0]   owner;
  logic [BCW-1:0]  beat_cnt;

  logic [SW-1:0]   gnt_idx;
  logic            gnt_any;

  logic            in_burst;
  logic            own_valid;
  logic            own_last;

  onehot_to_idx #(
    .N  (N),
    .SW (SW)
  ) u_gnt_idx (
    .onehot (arb_grant),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  assign in_burst  = (state == ST_BURST);
  assign own_valid = in_valid[owner];
  assign own_last  = in_last[owner] | (beat_cnt == LAST_CNT);

  assign out_valid = in_burst & own_valid;
  assign out_data  = in_burst ? in_data[int'(owner) * DW +: DW] : '0;
  assign out_last  = in_burst & own_last;
  assign in_ready  = in_burst ? ({{(N-1){1'b0}}, out_ready} << owner) : '0;

  // The request is only offered from IDLE, so the arbiter sees exactly one
  // pulse per arbitration. Gated by rst_n so nothing is driven during reset
  // even though IDLE is the reset state.
  assign arb_req   = (rst_n && state == ST_IDLE) ? in_valid : '0;

  assign out_src   = owner;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

`ifdef ARB_BURST_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);
  logic [TCW-1:0] stall_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      beat_cnt <= '0;
`ifdef ARB_BURST_TIMEOUT_EN
      stall_cnt <= '0;
      tmo_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|in_valid) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A zero grant is a protocol violation: drop back and re-request.
          if (gnt_any) begin
            owner    <= gnt_idx;
            beat_cnt <= '0;
            state    <= ST_BURST;
`ifdef ARB_BURST_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (own_valid && out_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (own_last) state <= ST_IDLE;
          end
`ifdef ARB_BURST_TIMEOUT_EN
          if (own_valid) begin
            stall_cnt <= '0;
          end else if (stall_cnt == TMO_LAST) begin
            state   <= ST_IDLE;
            tmo_err <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_burst_mux.sv
// tb_arb_burst_mux: bench for arb_burst_mux with N=4, DW=8, MAX_BURST=4 and a
// round-robin arbiter model in the loop. A transaction-level model predicts
// every output each cycle; directed scenarios pin it with literal values.
`timescale 1ns/1ps
module tb_arb_burst_mux;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SW = 2;
`ifdef ARB_BURST_TIMEOUT_EN
  localparam int TMO = 5;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready = 1'b1;
  logic [SW-1:0]   out_src;
  logic            busy;
  logic [1:0]      state_dbg;
`ifdef ARB_BURST_TIMEOUT_EN
  logic            tmo_err;
`endif

  arb_burst_mux #(
    .N         (N),
    .DW        (DW),
    .MAX_BURST (MB)
`ifdef ARB_BURST_TIMEOUT_EN
    , .TIMEOUT (TMO)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy),
    .state_dbg (state_dbg)
`ifdef ARB_BURST_TIMEOUT_EN
    , .tmo_err (tmo_err)
`endif
  );

  // ---------------- arbiter in the loop ----------------
  logic         ovr_en = 1'b0;
  logic [N-1:0] ovr_val = '0;
  int           arb_ptr;
  int           arb_w;

  function automatic int rr_pick(logic [N-1:0] req, int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_grant <= '0;
      arb_ptr   <= 0;
    end else if (arb_req == '0) begin
      arb_grant <= '0;
    end else if (ovr_en) begin
      arb_grant <= ovr_val;
    end else begin
      arb_w = rr_pick(arb_req, arb_ptr);
      arb_grant <= '0;
      arb_grant[arb_w] <= 1'b1;
      arb_ptr <= (arb_w + 1) % N;
    end
  end

  // ---------------- producers ----------------
  logic [DW:0]  mem [N][64];   // {last, data}
  int           hd [N];
  int           tl [N];
  logic [N-1:0] en = '0;
  int           bp_mode = 0;   // 0 hold, 1 toggle, 2 random
  bit           rnd_en = 1'b0;

  task automatic push(input int c, input logic [DW-1:0] d, input logic l);
    mem[c][tl[c]] = {l, d};
    tl[c]++;
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      logic [DW:0] b;
      b = mem[c][hd[c]];
      in_valid[c] = en[c] && (hd[c] < tl[c]);
      in_last[c]  = in_valid[c] & b[DW];
      in_data[c*DW +: DW] = in_valid[c] ? b[DW-1:0] : '0;
    end
  endtask

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit model_en = 1'b0;
  int m_owner;
  int m_beats;
  int m_stall;
  bit m_arb;
  bit m_tmo;

  int            req_cyc[$];
  logic [N-1:0]  req_val[$];
  int            tr_cyc[$];
  int            tr_src[$];
  logic [DW-1:0] tr_data[$];
  bit            tr_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_stall = 0;
    m_arb = 1'b0;
    m_tmo = 1'b0;
  endtask

  task automatic clear_logs();
    req_cyc.delete();
    req_val.delete();
    tr_cyc.delete();
    tr_src.delete();
    tr_data.delete();
    tr_last.delete();
  endtask

  // Predicts this cycle's outputs, compares, then advances one cycle.
  task automatic model_step();
    logic [N-1:0] e_req;
    logic [N-1:0] e_rdy;
    bit           e_busy;
    bit           e_val;
    bit           e_last;
    logic [DW:0]  hb;
    if (!model_en) return;
    e_busy = m_arb || (m_owner >= 0);
    e_req  = e_busy ? '0 : in_valid;
    e_val  = (m_owner >= 0) && in_valid[m_owner];
    e_rdy  = '0;
    if (m_owner >= 0 && out_ready) e_rdy[m_owner] = 1'b1;
    e_last = 1'b0;
    chk("arb_req", 32'(arb_req), 32'(e_req));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("out_valid", 32'(out_valid), 32'(e_val));
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    if (e_val) begin
      hb = mem[m_owner][hd[m_owner]];
      e_last = hb[DW] || (m_beats == MB - 1);
      chk("out_src", 32'(out_src), m_owner);
      chk("out_data", 32'(out_data), 32'(hb[DW-1:0]));
      chk("out_last", 32'(out_last), 32'(e_last));
    end
`ifdef ARB_BURST_TIMEOUT_EN
    chk("tmo_err", 32'(tmo_err), 32'(m_tmo));
`endif
    if (m_arb) begin
      m_arb = 1'b0;
      m_beats = 0;
      m_stall = 0;
      m_owner = -1;
      for (int i = N - 1; i >= 0; i--) if (arb_grant[i]) m_owner = i;
    end else if (m_owner < 0) begin
      if (in_valid != '0) m_arb = 1'b1;
    end else if (e_val) begin
      m_stall = 0;
      if (out_ready) begin
        m_beats++;
        if (e_last) m_owner = -1;
      end
    end else begin
`ifdef ARB_BURST_TIMEOUT_EN
      m_stall++;
      if (m_stall == TMO) begin
        m_owner = -1;
        m_tmo = 1'b1;
      end
`endif
    end
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    cyc++;
    model_step();
    if (arb_req != '0) begin
      req_cyc.push_back(cyc);
      req_val.push_back(arb_req);
    end
    if (out_valid && out_ready) begin
      tr_cyc.push_back(cyc);
      tr_src.push_back(int'(out_src));
      tr_data.push_back(out_data);
      tr_last.push_back(out_last);
    end
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) if (acc[c]) hd[c]++;
    if (bp_mode == 1) out_ready = ~out_ready;
    else if (bp_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    if (rnd_en) en = N'($urandom_range(0, 15));
    drive();
  endtask

  task automatic do_reset();
    model_en = 1'b0;
    rst_n = 1'b0;
    en = '0;
    rnd_en = 1'b0;
    bp_mode = 0;
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      hd[c] = 0;
      tl[c] = 0;
    end
    drive();
    repeat (2) cycle();
    rst_n = 1'b1;
    model_reset();
    model_en = 1'b1;
    clear_logs();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    do_reset();

    // Reset values
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_arb_req", 32'(arb_req), 0);

    // Single request on ch2
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    en = 4'b0100;
    drive();
    repeat (8) cycle();
    chk("t1_nreq", req_val.size(), 1);
    chk("t1_ntr", tr_src.size(), 3);
    if (req_val.size() == 1) chk("t1_req", 32'(req_val[0]), 32'h4);
    if (tr_src.size() == 3 && req_cyc.size() >= 1) begin
      chk("t1_latency", tr_cyc[0] - req_cyc[0], 2);
      for (int i = 0; i < 3; i++) begin
        chk("t1_src", tr_src[i], 2);
        chk("t1_data", 32'(tr_data[i]), 32'hA1 + i);
        chk("t1_last", 32'(tr_last[i]), (i == 2) ? 1 : 0);
      end
    end
    chk("t1_idle", 32'(busy), 0);

    // Round robin with four 1-beat producers
    do_reset();
    for (int c = 0; c < N; c++) begin
      push(c, 8'(8'h10 + c), 1'b1);
      push(c, 8'(8'h20 + c), 1'b1);
    end
    en = 4'hF;
    drive();
    repeat (16) cycle();
    chk("t2_ntr_ge5", 32'(tr_src.size() >= 5), 1);
    chk("t2_nreq_ge5", 32'(req_cyc.size() >= 5), 1);
    if (tr_src.size() >= 5 && req_cyc.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("t2_src", tr_src[i], i % 4);
        chk("t2_data", 32'(tr_data[i]), (i < 4) ? 32'h10 + i : 32'h20);
        chk("t2_req_cyc", req_cyc[i] - req_cyc[0], 3 * i);
        chk("t2_latency", tr_cyc[i] - req_cyc[i], 2);
      end
    end

    // Forced termination: 6 beats with no last
    do_reset();
    for (int k = 0; k < 6; k++) push(1, 8'(8'hB0 + k), 1'b0);
    en = 4'b0010;
    drive();
    repeat (14) cycle();
    chk("t3_ntr", tr_src.size(), 6);
    chk("t3_nreq", req_cyc.size(), 2);
    if (tr_src.size() == 6 && req_cyc.size() == 2) begin
      for (int i = 0; i < 6; i++) begin
        chk("t3_src", tr_src[i], 1);
        chk("t3_data", 32'(tr_data[i]), 32'hB0 + i);
        chk("t3_last", 32'(tr_last[i]), (i == 3) ? 1 : 0);
      end
      chk("t3_rearb", req_cyc[1] - tr_cyc[3], 1);
      chk("t3_resume", tr_cyc[4] - req_cyc[1], 2);
    end
    chk("t3_held", 32'(busy), 1);

    // Backpressure on a ch3 burst, other channels waiting
    do_reset();
    for (int k = 0; k < 4; k++) push(3, 8'(8'hC0 + k), (k == 3));
    for (int c = 0; c < 3; c++) push(c, 8'(8'h50 + c), 1'b1);
    en = 4'b1000;
    out_ready = 1'b0;
    bp_mode = 1;
    drive();
    cycle();
    en = 4'hF;
    drive();
    repeat (24) cycle();
    chk("t4_ntr", tr_src.size(), 7);
    if (tr_src.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_src", tr_src[i], 3);
        chk("t4_data", 32'(tr_data[i]), 32'hC0 + i);
        chk("t4_last", 32'(tr_last[i]), (i == 3) ? 1 : 0);
      end
      chk("t4_stall_gap", tr_cyc[1] - tr_cyc[0], 2);
    end

    // Reset in the middle of a 4-beat burst
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 8'(8'hD0 + k), (k == 3));
    en = 4'b0001;
    drive();
    for (int g = 0; g < 10 && tr_src.size() < 2; g++) cycle();
    chk("t5_two_beats", tr_src.size(), 2);
    model_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_out_last", 32'(out_last), 0);
    chk("t5_out_data", 32'(out_data), 0);
    chk("t5_in_ready", 32'(in_ready), 0);
    chk("t5_arb_req", 32'(arb_req), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_out_src", 32'(out_src), 0);
    chk("t5_state", 32'(state_dbg), 0);
    do_reset();
    chk("t5_state_after", 32'(state_dbg), 0);
    push(1, 8'hE0, 1'b1);
    en = 4'b0010;
    drive();
    repeat (6) cycle();
    chk("t5_nreq", req_val.size(), 1);
    chk("t5_ntr", tr_src.size(), 1);
    if (req_val.size() == 1 && tr_src.size() == 1) begin
      chk("t5_req", 32'(req_val[0]), 32'h2);
      chk("t5_src", tr_src[0], 1);
      chk("t5_data", 32'(tr_data[0]), 32'hE0);
      chk("t5_latency", tr_cyc[0] - req_cyc[0], 2);
    end

    // Zero grant: re-request, then normal burst
    do_reset();
    push(0, 8'hF0, 1'b1);
    ovr_en = 1'b1;
    ovr_val = 4'b0000;
    en = 4'b0001;
    drive();
    cycle();
    ovr_en = 1'b0;
    repeat (6) cycle();
    chk("t6_nreq", req_cyc.size(), 2);
    chk("t6_ntr", tr_src.size(), 1);
    if (req_cyc.size() == 2 && tr_src.size() == 1) begin
      chk("t6_retry", req_cyc[1] - req_cyc[0], 2);
      chk("t6_latency", tr_cyc[0] - req_cyc[1], 2);
      chk("t6_data", 32'(tr_data[0]), 32'hF0);
    end

    // Multi-hot grant: lowest set bit wins
    do_reset();
    push(1, 8'h61, 1'b1);
    push(2, 8'h62, 1'b1);
    ovr_en = 1'b1;
    ovr_val = 4'b0110;
    en = 4'b0110;
    drive();
    cycle();
    ovr_en = 1'b0;
    repeat (8) cycle();
    chk("t7_ntr", tr_src.size(), 2);
    if (tr_src.size() == 2) begin
      chk("t7_src0", tr_src[0], 1);
      chk("t7_data0", 32'(tr_data[0]), 32'h61);
      chk("t7_src1", tr_src[1], 2);
    end

`ifdef ARB_BURST_TIMEOUT_EN
    // Owner stalls for TMO cycles: abandoned without out_last
    do_reset();
    push(0, 8'h70, 1'b0);
    push(0, 8'h71, 1'b0);
    en = 4'b0001;
    drive();
    repeat (12) cycle();
    chk("t8_ntr", tr_src.size(), 2);
    if (tr_src.size() == 2) begin
      chk("t8_last0", 32'(tr_last[0]), 0);
      chk("t8_last1", 32'(tr_last[1]), 0);
      chk("t8_tmo_cyc", 32'(busy), 0);
    end
    chk("t8_tmo_err", 32'(tmo_err), 1);
`endif

    // Randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      int guard;
      bit drained;
      do_reset();
      for (int c = 0; c < N; c++) begin
        int n;
        n = $urandom_range(3, 20);
        for (int k = 0; k < n; k++)
          push(c, 8'($urandom_range(0, 255)), (k == n - 1) || ($urandom_range(0, 3) == 0));
      end
      bp_mode = 2;
      rnd_en = 1'b1;
      en = 4'hF;
      drive();
      guard = 0;
      drained = 1'b0;
      while (!drained && guard < 3000) begin
        cycle();
        guard++;
        drained = !busy;
        for (int c = 0; c < N; c++) if (hd[c] < tl[c]) drained = 1'b0;
      end
      chk("rnd_drain", 32'(drained), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
